// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and byte-engine signal bundle for i2c_cmd_arbiter.
// master = the arbiter; slave = the requesters plus byte engine.
interface i2c_cmd_arbiter_if;
  // Requester side; index 0 = requester A, index 1 = requester B
  logic [1:0]  req_valid;
  logic [1:0]  req_rw;
  logic [13:0] req_dev;
  logic [15:0] req_reg;
  logic [15:0] req_wdata;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [7:0]  req_rdata;

  // Byte-engine side
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [7:0]  rsp_data;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    output req_done, req_err, req_rdata,
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_data
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  req_done, req_err, req_rdata,
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_nack, rsp_data
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Two-requester round-robin I2C register transaction sequencer driving a byte engine.
// Optional response timeout enabled by defining I2C_CMD_ARBITER_TIMEOUT_EN.
module i2c_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              scl_4x,
  input  logic              rst,
  i2c_cmd_arbiter_if.master bus,
  output logic              busy
);

  typedef enum logic [3:0] {
    StIdle, StStart, StDevW, StReg, StWdata, StRstart, StDevR, StRdata, StStop, StDone
  } state_e;

  localparam logic [2:0] OpStart  = 3'd0;
  localparam logic [2:0] OpWrite  = 3'd1;
  localparam logic [2:0] OpRead   = 3'd2;
  localparam logic [2:0] OpRstart = 3'd3;
  localparam logic [2:0] OpStop   = 3'd4;

  state_e      state_q, state_d;
  logic        waiting_q, waiting_d;
  logic        err_q, err_d;
  logic        prio_q, prio_d;  // requester favoured when both are valid
  logic        grant_q, grant_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cmd_state;
  logic        accept;
  logic        timeout;

  assign cmd_state = (state_q != StIdle) && (state_q != StDone);
  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign busy      = (state_q != StIdle);

`ifdef I2C_CMD_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // A response arriving on the final cycle still wins over the timeout.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout   = 1'b0;
    if (accept) begin
      tmo_cnt_d = '0;
    end else if (waiting_q && !bus.rsp_valid) begin
      if (tmo_cnt_q == TimeoutLast) begin
        timeout   = 1'b1;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge scl_4x) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Command presented by the current state; held constant until accepted.
  always_comb begin
    bus.cmd_valid = cmd_state && !waiting_q;
    bus.cmd_op    = OpStart;
    bus.cmd_data  = '0;
    unique case (state_q)
      StStart:  bus.cmd_op = OpStart;
      StDevW: begin
        bus.cmd_op   = OpWrite;
        bus.cmd_data = {dev_q, 1'b0};
      end
      StReg: begin
        bus.cmd_op   = OpWrite;
        bus.cmd_data = reg_q;
      end
      StWdata: begin
        bus.cmd_op   = OpWrite;
        bus.cmd_data = wdata_q;
      end
      StRstart: bus.cmd_op = OpRstart;
      StDevR: begin
        bus.cmd_op   = OpWrite;
        bus.cmd_data = {dev_q, 1'b1};
      end
      StRdata:  bus.cmd_op = OpRead;
      StStop:   bus.cmd_op = OpStop;
      default:  ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    waiting_d     = waiting_q;
    err_d         = err_q;
    prio_d        = prio_q;
    grant_d       = grant_q;
    rw_d          = rw_q;
    dev_d         = dev_q;
    reg_d         = reg_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    bus.req_done  = '0;
    bus.req_err   = '0;
    bus.req_rdata = '0;

    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          grant_d = (&bus.req_valid) ? prio_q : bus.req_valid[1];
          prio_d  = ~grant_d;
          rw_d    = grant_d ? bus.req_rw[1]       : bus.req_rw[0];
          dev_d   = grant_d ? bus.req_dev[13:7]   : bus.req_dev[6:0];
          reg_d   = grant_d ? bus.req_reg[15:8]   : bus.req_reg[7:0];
          wdata_d = grant_d ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = StStart;
        end
      end

      StDone: begin
        bus.req_done[grant_q] = 1'b1;
        bus.req_err[grant_q]  = err_q;
        bus.req_rdata         = err_q ? 8'h00 : rdata_q;
        err_d                 = 1'b0;
        state_d               = StIdle;
      end

      default: begin
        if (accept) begin
          waiting_d = 1'b1;
        end else if (waiting_q && bus.rsp_valid) begin
          waiting_d = 1'b0;
          // A NACK after any address/data byte skips straight to STOP.
          if (bus.rsp_nack && (state_q == StDevW || state_q == StReg ||
                               state_q == StWdata || state_q == StDevR)) begin
            err_d   = 1'b1;
            state_d = StStop;
          end else begin
            unique case (state_q)
              StStart:  state_d = StDevW;
              StDevW:   state_d = StReg;
              StReg:    state_d = rw_q ? StRstart : StWdata;
              StWdata:  state_d = StStop;
              StRstart: state_d = StDevR;
              StDevR:   state_d = StRdata;
              StRdata: begin
                rdata_d = bus.rsp_data;
                state_d = StStop;
              end
              StStop:   state_d = StDone;
              default:  state_d = StIdle;
            endcase
          end
        end else if (timeout) begin
          waiting_d = 1'b0;
          err_d     = 1'b1;
          state_d   = (state_q == StStop) ? StDone : StStop;
        end
      end
    endcase
  end

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      state_q   <= StIdle;
      waiting_q <= 1'b0;
      err_q     <= 1'b0;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waiting_q <= waiting_d;
      err_q     <= err_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a behavioural byte engine that logs commands.
// The timeout case runs only when I2C_CMD_ARBITER_TIMEOUT_EN is defined.
module tb_i2c_cmd_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_cmd_arbiter_if bus ();

  i2c_cmd_arbiter #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .scl_4x(clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] cmd(input logic [2:0] op, input logic [7:0] d);
    return {op, d};
  endfunction

  // Engine model state
  logic [10:0] log_q[$];
  int          seen_cyc_q[$];
  logic [10:0] exp_q[$];
  int          nack_idx   = -1;
  int          mute_idx   = -1;
  int          stall_idx  = -1;
  int          stall_left = 0;
  logic [10:0] stall_exp  = '0;
  logic [7:0]  rd_byte    = '0;
  bit          acc_pend   = 0;
  int          acc_idx    = 0;
  logic [2:0]  acc_op     = '0;

  // Accept at the edge after cmd_valid is seen; respond on the following edge.
  initial begin : engine
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      bus.rsp_data  = '0;
      if (acc_pend) begin
        acc_pend = 0;
        if (acc_idx != mute_idx) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_nack  = (acc_idx == nack_idx);
          bus.rsp_data  = (acc_op == 3'd2) ? rd_byte : 8'h00;
        end
      end
      if (bus.cmd_valid === 1'b1) begin
        if (log_q.size() == stall_idx && stall_left > 0) begin
          bus.cmd_ready = 1'b0;
          stall_left--;
          check("stall_cmd", {bus.cmd_op, bus.cmd_data}, stall_exp);
        end else begin
          bus.cmd_ready = 1'b1;
          acc_idx = log_q.size();
          acc_op  = bus.cmd_op;
          log_q.push_back({bus.cmd_op, bus.cmd_data});
          seen_cyc_q.push_back(cyc);
          acc_pend = 1;
        end
      end else begin
        bus.cmd_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_eng();
    log_q.delete();
    seen_cyc_q.delete();
    exp_q.delete();
    nack_idx   = -1;
    mute_idx   = -1;
    stall_idx  = -1;
    stall_left = 0;
    acc_pend   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_dev   = '0;
    bus.req_reg   = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_eng();
  endtask

  task automatic set_req(input int who, input bit rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd);
    if (who == 0) begin
      bus.req_rw[0]       = rw;
      bus.req_dev[6:0]    = dev;
      bus.req_reg[7:0]    = rg;
      bus.req_wdata[7:0]  = wd;
      bus.req_valid[0]    = 1'b1;
    end else begin
      bus.req_rw[1]       = rw;
      bus.req_dev[13:7]   = dev;
      bus.req_reg[15:8]   = rg;
      bus.req_wdata[15:8] = wd;
      bus.req_valid[1]    = 1'b1;
    end
  endtask

  // Raise a request, then once granted drop valid and scramble the fields.
  task automatic start_req(input int who, input bit rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
    bit granted = 0;
    @(negedge clk);
    set_req(who, rw, dev, rg, wd);
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      granted = (busy === 1'b1);
    end
    if (!granted) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_wait: busy never rose");
    end
    bus.req_valid = '0;
    bus.req_rw    = ~bus.req_rw;
    bus.req_dev   = ~bus.req_dev;
    bus.req_reg   = ~bus.req_reg;
    bus.req_wdata = ~bus.req_wdata;
  endtask

  task automatic wait_done(output logic [1:0] done, output logic [1:0] err,
                           output logic [7:0] rdata);
    done  = '0;
    err   = '0;
    rdata = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_done !== 2'b00) begin
        done  = bus.req_done;
        err   = bus.req_err;
        rdata = bus.req_rdata;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_wait: no req_done within 300 cycles");
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
    check({tag, "_cmd_op"},    bus.cmd_op,    0);
    check({tag, "_cmd_data"},  bus.cmd_data,  0);
    check({tag, "_done"},      bus.req_done,  0);
    check({tag, "_err"},       bus.req_err,   0);
    check({tag, "_rdata"},     bus.req_rdata, 0);
  endtask

  logic [1:0] d, e;
  logic [7:0] rd;

  initial begin : main
    rst = 1'b1;
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");

    // Write by A: dev 0x08 reg 0x92 data 0xAC
    start_req(0, 1'b0, 7'h08, 8'h92, 8'hAC);
    wait_done(d, e, rd);
    check("wr_done", d, 2'b01);
    check("wr_err", e, 2'b00);
    check("wr_rdata", rd, 8'h00);
    exp_q = {cmd(0, 8'h00), cmd(1, 8'h10), cmd(1, 8'h92), cmd(1, 8'hAC), cmd(4, 8'h00)};
    check_seq("wr");
    clear_eng();

    // Read by B: dev 0x08 reg 0x92, engine returns 0x5A
    rd_byte = 8'h5A;
    start_req(1, 1'b1, 7'h08, 8'h92, 8'h00);
    wait_done(d, e, rd);
    check("rd_done", d, 2'b10);
    check("rd_err", e, 2'b00);
    check("rd_rdata", rd, 8'h5A);
    exp_q = {cmd(0, 8'h00), cmd(1, 8'h10), cmd(1, 8'h92), cmd(3, 8'h00), cmd(1, 8'h11),
             cmd(2, 8'h00), cmd(4, 8'h00)};
    check_seq("rd");

    // Both valid after reset: A, B, then A again
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, 7'h08, 8'h01, 8'h02);
    set_req(1, 1'b0, 7'h20, 8'h03, 8'h04);
    wait_done(d, e, rd);
    check("rr_first", d, 2'b01);
    wait_done(d, e, rd);
    check("rr_second", d, 2'b10);
    wait_done(d, e, rd);
    check("rr_third", d, 2'b01);
    @(negedge clk);
    check("rr_no_b2b_grant", busy, 0);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    check("rr_idle", busy, 0);
    clear_eng();

    // NACK on the device-address write aborts to STOP
    nack_idx = 1;
    start_req(0, 1'b1, 7'h08, 8'h92, 8'h00);
    wait_done(d, e, rd);
    check("nack_done", d, 2'b01);
    check("nack_err", e, 2'b01);
    check("nack_rdata", rd, 8'h00);
    exp_q = {cmd(0, 8'h00), cmd(1, 8'h10), cmd(4, 8'h00)};
    check_seq("nack");
    clear_eng();

    // cmd_ready held low for 5 cycles on the device-address write
    stall_idx  = 1;
    stall_left = 5;
    stall_exp  = cmd(1, 8'h54);
    start_req(0, 1'b0, 7'h2A, 8'h33, 8'h44);
    wait_done(d, e, rd);
    check("stall_consumed", stall_left, 0);
    check("stall_done", d, 2'b01);
    check("stall_err", e, 2'b00);
    exp_q = {cmd(0, 8'h00), cmd(1, 8'h54), cmd(1, 8'h33), cmd(1, 8'h44), cmd(4, 8'h00)};
    check_seq("stall");
    clear_eng();

    // Reset while waiting on the READ: no STOP, no req_done
    mute_idx = 5;
    start_req(1, 1'b1, 7'h08, 8'h92, 8'h00);
    for (int i = 0; i < 200 && log_q.size() < 6; i++) @(negedge clk);
    check("rst_reached_read", log_q.size(), 6);
    @(negedge clk);
    check("rst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    begin
      bit saw_done = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.req_done !== 2'b00) saw_done = 1;
      end
      check("rst_no_done", saw_done, 0);
    end
    check("rst_no_stop", log_q.size(), 6);

`ifdef I2C_CMD_ARBITER_TIMEOUT_EN
    // No response after REG accept: STOP after 16 waiting cycles, error reported
    do_reset();
    mute_idx = 2;
    start_req(0, 1'b0, 7'h08, 8'h92, 8'hAC);
    wait_done(d, e, rd);
    check("tmo_done", d, 2'b01);
    check("tmo_err", e, 2'b01);
    exp_q = {cmd(0, 8'h00), cmd(1, 8'h10), cmd(1, 8'h92), cmd(4, 8'h00)};
    check_seq("tmo");
    // Accept edge is one after REG is seen; STOP appears 16 edges after that.
    if (seen_cyc_q.size() >= 4)
      check("tmo_delay", seen_cyc_q[3] - seen_cyc_q[2], 17);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
